// File: rtl/fencei_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fencei_sequencer_if : pipeline <-> FENCE.I sequencer handshake bundle       |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface fencei_sequencer_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
);
   logic             fencei_i;
   logic [XLEN-1:0]  fencei_pc_i;
   logic             sys_jump_i;
   logic             mem_busy_i;
   logic             dc_flush_done_i;
   logic             ic_inv_done_i;
   logic             stall_o;
   logic             dc_flush_req_o;
   logic             ic_inv_req_o;
   logic             restart_o;
   logic [XLEN-1:0]  restart_pc_o;
   logic             busy_o;
   logic [CNT_W-1:0] fencei_cnt_o;

   // Pipeline / cache side: drives requests and completions, observes control.
   modport master (
      output fencei_i, fencei_pc_i, sys_jump_i, mem_busy_i,
             dc_flush_done_i, ic_inv_done_i,
      input  stall_o, dc_flush_req_o, ic_inv_req_o, restart_o,
             restart_pc_o, busy_o, fencei_cnt_o
   );

   // Sequencer side.
   modport slave (
      input  fencei_i, fencei_pc_i, sys_jump_i, mem_busy_i,
             dc_flush_done_i, ic_inv_done_i,
      output stall_o, dc_flush_req_o, ic_inv_req_o, restart_o,
             restart_pc_o, busy_o, fencei_cnt_o
   );
endinterface
`default_nettype wire

// File: rtl/fencei_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fencei_sequencer : freeze, drain, D$ write-back, I$ invalidate, restart    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module fencei_sequencer #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  wire             clk_i,
   input  wire             rst_i,
   fencei_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DRAIN   = 3'd1,
      ST_DFLUSH  = 3'd2,
      ST_IINV    = 3'd3,
      ST_RESTART = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [XLEN-1:0]  r_restart_pc;
   logic [CNT_W-1:0] r_cnt;
   logic             w_accept;

   // A trap from an older instruction always beats a new FENCE.I.
   assign w_accept = (r_state == ST_IDLE) && bus.fencei_i && !bus.sys_jump_i;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state      <= ST_IDLE;
         r_restart_pc <= '0;
         r_cnt        <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept)
            r_restart_pc <= bus.fencei_pc_i + XLEN'(4);
         if (r_state == ST_RESTART)
            r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept)
               w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (bus.sys_jump_i)
               w_state_nxt = ST_IDLE;
            else if (!bus.mem_busy_i)
               w_state_nxt = ST_DFLUSH;
         end
         // Once a cache operation starts it runs to completion, traps or not.
         ST_DFLUSH: begin
            if (bus.dc_flush_done_i)
               w_state_nxt = ST_IINV;
         end
         ST_IINV: begin
            if (bus.ic_inv_done_i)
               w_state_nxt = ST_RESTART;
         end
         ST_RESTART: w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   // The IDLE term holds the FENCE.I in Execute during its arrival cycle;
   // RESTART releases it so it moves on while younger stages are flushed.
   assign bus.stall_o        = (r_state == ST_DRAIN) || (r_state == ST_DFLUSH) ||
                               (r_state == ST_IINV)  || w_accept;
   assign bus.dc_flush_req_o = (r_state == ST_DFLUSH);
   assign bus.ic_inv_req_o   = (r_state == ST_IINV);
   assign bus.restart_o      = (r_state == ST_RESTART);
   assign bus.busy_o         = (r_state != ST_IDLE);
   assign bus.restart_pc_o   = r_restart_pc;
   assign bus.fencei_cnt_o   = r_cnt;

`ifndef SYNTHESIS
   a_req_exclusive : assert property (@(posedge clk_i) disable iff (!rst_i)
      !(bus.dc_flush_req_o && bus.ic_inv_req_o));
   a_restart_single : assert property (@(posedge clk_i) disable iff (!rst_i)
      bus.restart_o |=> !bus.restart_o);
`endif

endmodule
`default_nettype wire

// File: tb/tb_fencei_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fencei_sequencer : directed self-checking bench for fencei_sequencer    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_fencei_sequencer;
   localparam int XLEN  = 32;
   localparam int CNT_W = 2;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   logic [CNT_W-1:0] exp_cnt = '0;

   fencei_sequencer_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

   fencei_sequencer #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus.slave)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Drives one full FENCE.I with given drain/done delays; fencei_i stays high
   // through the RESTART cycle to prove it does not retrigger.
   task automatic run_seq(input logic [XLEN-1:0] pc, input int busy_n, input int dwait,
                          input int iwait, input bit stray_ic, input bit jump_dflush);
      logic [XLEN-1:0] exp_pc;
      exp_pc = pc + 32'd4;
      bus.fencei_i = 1'b1; bus.fencei_pc_i = pc; bus.mem_busy_i = 1'b0;
      #1;
      chk("t_stall", bus.stall_o, 1);
      chk("t_busy", bus.busy_o, 0);
      tick();
      for (int i = 0; i <= busy_n; i++) begin
         bus.mem_busy_i = (i < busy_n);
         #1;
         chk("drain_busy", bus.busy_o, 1);
         chk("drain_stall", bus.stall_o, 1);
         chk("drain_dreq", bus.dc_flush_req_o, 0);
         chk("drain_pc", bus.restart_pc_o, exp_pc);
         tick();
      end
      bus.mem_busy_i = 1'b0;
      for (int i = 0; i <= dwait; i++) begin
         bus.dc_flush_done_i = (i == dwait);
         bus.ic_inv_done_i   = stray_ic && (i == 0);
         bus.sys_jump_i      = jump_dflush && (i == 0);
         #1;
         chk("dfl_dreq", bus.dc_flush_req_o, 1);
         chk("dfl_ireq", bus.ic_inv_req_o, 0);
         chk("dfl_stall", bus.stall_o, 1);
         tick();
      end
      bus.dc_flush_done_i = 1'b0; bus.sys_jump_i = 1'b0;
      for (int i = 0; i <= iwait; i++) begin
         bus.ic_inv_done_i = (i == iwait);
         #1;
         chk("iinv_ireq", bus.ic_inv_req_o, 1);
         chk("iinv_dreq", bus.dc_flush_req_o, 0);
         chk("iinv_rst", bus.restart_o, 0);
         tick();
      end
      bus.ic_inv_done_i = 1'b0;
      #1;
      chk("rs_restart", bus.restart_o, 1);
      chk("rs_stall", bus.stall_o, 0);
      chk("rs_busy", bus.busy_o, 1);
      chk("rs_pc", bus.restart_pc_o, exp_pc);
      chk("rs_cnt", bus.fencei_cnt_o, exp_cnt);
      tick();
      exp_cnt = exp_cnt + 2'd1;
      bus.fencei_i = 1'b0;
      #1;
      chk("post_restart", bus.restart_o, 0);
      chk("post_busy", bus.busy_o, 0);
      chk("post_cnt", bus.fencei_cnt_o, exp_cnt);
   endtask

   initial begin
      bus.fencei_i = 1'b0; bus.fencei_pc_i = '0; bus.sys_jump_i = 1'b0;
      bus.mem_busy_i = 1'b0; bus.dc_flush_done_i = 1'b0; bus.ic_inv_done_i = 1'b0;
      tick(); tick();
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_stall", bus.stall_o, 0);
      chk("rst_pc", bus.restart_pc_o, 0);
      chk("rst_cnt", bus.fencei_cnt_o, 0);
      chk("rst_dreq", bus.dc_flush_req_o, 0);
      chk("rst_restart", bus.restart_o, 0);
      bus.fencei_i = 1'b1;
      #1;
      chk("rst_stall_comb", bus.stall_o, 1);
      tick();
      chk("rst_hold_idle", bus.busy_o, 0);
      bus.fencei_i = 1'b0;
      rst_i = 1'b1;
      tick();

      // basic and drain-wait sequences
      run_seq(32'h0000_1000, 0, 0, 0, 1'b0, 1'b0);
      run_seq(32'h0000_1100, 5, 0, 0, 1'b0, 1'b0);

      // trap together with FENCE.I in IDLE
      bus.fencei_i = 1'b1; bus.fencei_pc_i = 32'h0000_5000; bus.sys_jump_i = 1'b1;
      #1;
      chk("trap_idle_stall", bus.stall_o, 0);
      tick();
      bus.fencei_i = 1'b0; bus.sys_jump_i = 1'b0;
      #1;
      chk("trap_idle_busy", bus.busy_o, 0);
      chk("trap_idle_pc", bus.restart_pc_o, 32'h0000_1104);

      // trap in DRAIN abandons the sequence
      bus.fencei_i = 1'b1; bus.fencei_pc_i = 32'h0000_2000;
      tick();
      bus.fencei_i = 1'b0; bus.mem_busy_i = 1'b1; bus.sys_jump_i = 1'b1;
      #1;
      chk("trap_drain_busy", bus.busy_o, 1);
      chk("trap_drain_dreq", bus.dc_flush_req_o, 0);
      tick();
      bus.mem_busy_i = 1'b0; bus.sys_jump_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("trap_drain_idle", bus.busy_o, 0);
         chk("trap_drain_nodreq", bus.dc_flush_req_o, 0);
         chk("trap_drain_noireq", bus.ic_inv_req_o, 0);
         chk("trap_drain_norst", bus.restart_o, 0);
         tick();
      end
      chk("trap_drain_cnt", bus.fencei_cnt_o, exp_cnt);
      chk("trap_drain_pc", bus.restart_pc_o, 32'h0000_2004);

      // trap in DFLUSH is ignored
      run_seq(32'h0000_3000, 1, 2, 0, 1'b0, 1'b1);

      // stray dones: D$ done in IDLE, I$ done during DFLUSH
      bus.dc_flush_done_i = 1'b1;
      #1;
      tick();
      bus.dc_flush_done_i = 1'b0;
      #1;
      chk("stray_dc_idle", bus.busy_o, 0);
      chk("stray_dc_dreq", bus.dc_flush_req_o, 0);
      exp_cnt = bus.fencei_cnt_o == exp_cnt ? exp_cnt : exp_cnt;
      run_seq(32'h0000_4000, 0, 1, 2, 1'b1, 1'b0);

      // reset while in IINV
      bus.fencei_i = 1'b1; bus.fencei_pc_i = 32'h0000_6000;
      tick();
      tick();
      bus.dc_flush_done_i = 1'b1;
      tick();
      bus.dc_flush_done_i = 1'b0;
      #1;
      chk("mid_ireq", bus.ic_inv_req_o, 1);
      rst_i = 1'b0;
      tick();
      rst_i = 1'b1; bus.fencei_i = 1'b0;
      #1;
      chk("mid_busy", bus.busy_o, 0);
      chk("mid_ireq_drop", bus.ic_inv_req_o, 0);
      chk("mid_pc", bus.restart_pc_o, 0);
      chk("mid_restart", bus.restart_o, 0);
      chk("mid_cnt", bus.fencei_cnt_o, 0);
      exp_cnt = '0;
      tick();
      chk("mid_restart2", bus.restart_o, 0);

      // four sequences wrap the 2-bit counter; one also wraps the PC
      run_seq(32'hFFFF_FFFC, 0, 0, 0, 1'b0, 1'b0);
      run_seq(32'h0000_0010, 2, 1, 1, 1'b0, 1'b0);
      run_seq(32'h8000_0000, 0, 3, 0, 1'b0, 1'b0);
      run_seq(32'h0000_0FFC, 1, 0, 3, 1'b0, 1'b0);
      chk("cnt_wrap", bus.fencei_cnt_o, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/fencei_sequencer.md
# fencei_sequencer

Multi-cycle sequencer for FENCE.I in the Aquila core. When FENCE.I reaches Execute, the block does four things in order:
- freezes the front of the pipeline;
- drains the Memory stage;
- writes back the D-cache, then invalidates the I-cache;
- issues a one-cycle restart that flushes Fetch/Decode/Execute and redirects the PC to the instruction after the FENCE.I.

It sits beside the pipeline controller and feeds its stall and flush inputs.

## Interface
Parameters:
- XLEN, 32, address width of PCs.
- CNT_W, 32, width of the completed-FENCE.I performance counter.

Ports:
- clk_i  input  1  core clock; the block uses this single clock.
- rst_i  input  1  reset; synchronous and active-low.
- fencei_i  input  1  a valid FENCE.I is in Execute this cycle.
- fencei_pc_i  input  XLEN  PC of that FENCE.I.
- sys_jump_i  input  1  trap/xRET redirect from an older instruction.
- mem_busy_i  input  1  Memory stage holds an outstanding load/store.
- dc_flush_done_i  input  1  D-cache write-back complete (1-cycle pulse).
- ic_inv_done_i  input  1  I-cache invalidate complete (1-cycle pulse).
- stall_o  output  1  stall PCU, Fetch, Decode and Execute.
- dc_flush_req_o  output  1  D-cache write-back request (level).
- ic_inv_req_o  output  1  I-cache invalidate request (level).
- restart_o  output  1  flush Fetch/Decode/Execute and load restart_pc_o into the PC.
- restart_pc_o  output  XLEN  restart target.
- busy_o  output  1  state is not IDLE.
- fencei_cnt_o  output  CNT_W  number of completed sequences.

## Operation
States: IDLE, DRAIN, DFLUSH, IINV, RESTART. All state is held in a registered FSM; outputs are Moore except stall_o.

- **IDLE**
  - If fencei_i=1 and sys_jump_i=0: capture restart_pc_o <= fencei_pc_i + 4 (mod 2^XLEN), then go to DRAIN.
  - If fencei_i=1 and sys_jump_i=1: the trap wins. Capture nothing, stay in IDLE.
- **DRAIN**
  - If sys_jump_i=1: go to IDLE. No cache operations are issued and the counter is unchanged.
  - Else if mem_busy_i=0: go to DFLUSH.
  - Else stay in DRAIN.
- **DFLUSH**
  - dc_flush_req_o=1.
  - On dc_flush_done_i=1 (including the first cycle in the state): go to IINV.
  - sys_jump_i is ignored here; a started cache operation always completes.
- **IINV**
  - ic_inv_req_o=1.
  - On ic_inv_done_i=1: go to RESTART.
  - sys_jump_i is ignored.
- **RESTART**
  - restart_o=1 for exactly this cycle.
  - fencei_cnt_o increments, wrapping at 2^CNT_W.
  - Next state is IDLE unconditionally.

Output equations:
- stall_o = (state in {DRAIN, DFLUSH, IINV}) | (state==IDLE & fencei_i & !sys_jump_i). The combinational term freezes the FENCE.I in Execute in its arrival cycle.
- stall_o=0 in RESTART, so the FENCE.I advances to Memory while the younger stages are flushed.
- busy_o=1 in every state except IDLE.

Input handling:
- fencei_i is ignored in every state except IDLE. In the RESTART cycle it is still high for the same instruction and must not retrigger.
- A done pulse arriving in a state other than the one that owns it is ignored and is not remembered.
- restart_pc_o holds its captured value until the next capture.

## Timing
- Reset (rst_i=0 at a clock edge):
  - state=IDLE, restart_pc_o=0, fencei_cnt_o=0.
  - All 1-bit outputs are 0, except that stall_o still follows its combinational IDLE term.
- Reset takes effect even in mid-sequence: any pending request is dropped and no restart is issued.
- Minimum latency, with fencei_i at cycle t, mem_busy_i=0, and each done arriving in the first cycle its request is asserted:
  - DRAIN at t+1, DFLUSH at t+2, IINV at t+3, RESTART at t+4.
  - restart_o=1 in cycle t+4.
- In general, latency = 4 + (cycles mem_busy_i stays high in DRAIN) + (extra wait for each done).
- Request levels rise in the first cycle of their state and fall in the cycle after the done pulse. They never overlap.

## Test plan
1. **Basic sequence.** fencei_i=1, fencei_pc_i=0x0000_1000, mem_busy_i=0, dones returned immediately.
   - Required: restart_o pulses at t+4 with restart_pc_o=0x0000_1004.
   - Required: fencei_cnt_o goes 0->1; stall_o=1 in cycles t..t+3.
2. **Drain wait.** mem_busy_i held high for 5 cycles after fencei_i.
   - Required: dc_flush_req_o first asserts 1 cycle after mem_busy_i falls.
   - Required: restart_o at t+9.
3. **Trap precedence.**
   - (a) sys_jump_i and fencei_i both high in IDLE: state stays IDLE, stall_o=0.
   - (b) sys_jump_i in DRAIN: return to IDLE; no request is ever asserted; counter unchanged.
   - (c) sys_jump_i in DFLUSH: ignored; sequence completes with restart_o.
4. **Stray dones.** ic_inv_done_i pulsed during DFLUSH, and dc_flush_done_i pulsed in IDLE.
   - Required: no state change; IINV still waits for a fresh ic_inv_done_i.
5. **PC wrap.** fencei_pc_i=0xFFFF_FFFC -> restart_pc_o=0x0000_0000.
6. **Reset mid-operation and counter wrap.**
   - rst_i=0 during IINV: next cycle state is IDLE, ic_inv_req_o=0, restart_pc_o=0, no restart_o.
   - With CNT_W=2, four sequences return fencei_cnt_o to 0.
